// File: rtl/uart_fifo_mm.sv
// Memory-mapped UART front end: RX/TX byte FIFOs behind a 4-word port-B register window.
// Bus read data/strobe one cycle after address; DATA write reaches tx_tvalid two cycles later.
// RX never stalls (overflow drops + sticky flag); TX output register holds while tx_tready=0.
// Optional build macro UART_FIFO_IRQ_EN adds the irq output and the IRQEN register at BASE+3.
module uart_fifo_mm #(
    parameter logic [31:0] BASE_ADDR = 32'd65544,
    parameter int          AW        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_b,
    input  logic [31:0] data_b_in,
    input  logic [31:0] data_b_we,
    output logic [31:0] data_b,
    output logic        strobe_b,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready
`ifdef UART_FIFO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    // ---------------- bus decode ----------------
    logic [31:0] off;
    logic        in_win;
    logic        wr_en;
    logic        rd_data_sel;
    logic        wr_data_sel;
    logic        wr_status_sel;

    assign off           = addr_b - BASE_ADDR;
    assign in_win        = (off < 32'd4);
    assign wr_en         = |data_b_we;
    assign rd_data_sel   = in_win & ~wr_en & (off[1:0] == 2'd1);
    assign wr_data_sel   = in_win &  wr_en & (off[1:0] == 2'd1);
    assign wr_status_sel = in_win &  wr_en & (off[1:0] == 2'd0);

    // Only the low byte of write data carries meaning for any register.
    logic unused_wdat;
    assign unused_wdat = ^data_b_in[31:8];

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr;
    logic [AW-1:0] rx_rd_ptr;
    logic [AW:0]   rx_cnt;
    logic          rx_empty;
    logic          rx_full;
    logic          rx_pop;
    logic          rx_push;
    logic          rx_ovf_set;
    logic [7:0]    rx_head;

    assign rx_empty   = (rx_cnt == '0);
    assign rx_full    = rx_cnt[AW];
    assign rx_head    = rx_mem[rx_rd_ptr];
    assign rx_pop     = rd_data_sel & ~rx_empty;
    // A same-cycle CPU pop frees a slot, so a full FIFO can still accept.
    assign rx_push    = rx_tvalid & (~rx_full | rx_pop);
    assign rx_ovf_set = rx_tvalid & ~rx_push;
    assign rx_tready  = 1'b1;

    // RX storage write (no reset needed: validity tracked by pointers/count)
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_tdata;
    end

    // RX pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
                2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr;
    logic [AW-1:0] tx_rd_ptr;
    logic [AW:0]   tx_cnt;
    logic          tx_empty;
    logic          tx_full;
    logic          tx_load;
    logic          tx_pop;
    logic          tx_push;
    logic          tx_ovf_set;
    logic [7:0]    tx_head;
    logic          tx_idle;

    assign tx_empty   = (tx_cnt == '0);
    assign tx_full    = tx_cnt[AW];
    assign tx_head    = tx_mem[tx_rd_ptr];
    // Output register can take a new byte when idle or when its byte leaves this cycle.
    assign tx_load    = ~tx_tvalid | tx_tready;
    assign tx_pop     = tx_load & ~tx_empty;
    assign tx_push    = wr_data_sel & (~tx_full | tx_pop);
    assign tx_ovf_set = wr_data_sel & ~tx_push;
    assign tx_idle    = tx_empty & ~tx_tvalid;

    // TX storage write
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= data_b_in[7:0];
    end

    // TX pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
                2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    // One-entry output register: refill from FIFO head, hold while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_tvalid <= 1'b0;
            tx_tdata  <= 8'd0;
        end else if (tx_load) begin
            tx_tvalid <= ~tx_empty;
            if (!tx_empty) tx_tdata <= tx_head;
        end
    end

    // ---------------- sticky overflow flags ----------------
    logic rx_ovf;
    logic tx_ovf;

    // Overflow flags: a set in the same cycle as a W1C clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            rx_ovf <= rx_ovf_set | (rx_ovf & ~(wr_status_sel & data_b_in[2]));
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(wr_status_sel & data_b_in[3]));
        end
    end

`ifdef UART_FIFO_IRQ_EN
    logic rx_irq_en;
    logic tx_irq_en;
    logic wr_irqen_sel;

    assign wr_irqen_sel = in_win & wr_en & (off[1:0] == 2'd3);

    // IRQ enables and registered interrupt output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_irqen_sel) begin
                rx_irq_en <= data_b_in[0];
                tx_irq_en <= data_b_in[1];
            end
            irq <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_idle);
        end
    end
`endif

    // ---------------- read mux ----------------
    logic [31:0] status_word;
    logic [31:0] count_word;
    logic [31:0] rd_val;

    // Assemble status/count words and select the read value for the decoded register
    always_comb begin
        status_word                = '0;
        status_word[0]             = ~rx_empty;
        status_word[1]             = ~tx_full;
        status_word[2]             = rx_ovf;
        status_word[3]             = tx_ovf;
        status_word[4]             = tx_idle;
        count_word                 = '0;
        count_word[AW:0]           = rx_cnt;
        count_word[AW+16:16]       = tx_cnt;
        rd_val                     = '0;
        case (off[1:0])
            2'd0: rd_val = status_word;
            2'd1: if (!wr_en && !rx_empty) rd_val = {24'd0, rx_head};
            2'd2: rd_val = count_word;
`ifdef UART_FIFO_IRQ_EN
            2'd3: rd_val = {30'd0, tx_irq_en, rx_irq_en};
`else
            2'd3: rd_val = '0;
`endif
            default: rd_val = '0;
        endcase
    end

    // Registered bus response, zero outside the window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_b   <= '0;
            strobe_b <= 1'b0;
        end else begin
            strobe_b <= in_win;
            data_b   <= in_win ? rd_val : '0;
        end
    end

endmodule
